// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with saturating direction counters and stats
// Optional gshare counter indexing is enabled by defining BTP_GSHARE_EN.
module branch_target_predictor #(
  parameter int AW     = 32,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [AW-1:0]     i_lk_pc,
  output logic              o_pred_hit,
  output logic              o_pred_taken,
  output logic [AW-1:0]     o_pred_target,
  input  logic              i_upd_valid,
  input  logic [AW-1:0]     i_upd_pc,
  input  logic              i_upd_jump,
  input  logic              i_upd_taken,
  input  logic [AW-1:0]     i_upd_target,
  input  logic              i_upd_mispred,
  output logic [STAT_W-1:0] o_stat_branches,
  output logic [STAT_W-1:0] o_stat_mispred
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = AW - IDX_W - 2;
  localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_WT - CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_jflag;
  logic [TAG_W-1:0]  r_tag    [DEPTH];
  logic [AW-1:0]     r_target [DEPTH];
  logic [CNT_W-1:0]  r_cnt    [DEPTH];
  logic [STAT_W-1:0] r_stat_br;
  logic [STAT_W-1:0] r_stat_mp;

  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_lk_cidx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic [CNT_W-1:0]  w_lk_cnt;
  logic              w_lk_hit;
  logic              w_lk_taken;
  logic [IDX_W-1:0]  w_up_idx;
  logic [IDX_W-1:0]  w_up_cidx;
  logic [TAG_W-1:0]  w_up_tag;
  logic [CNT_W-1:0]  w_up_cnt;
  logic              w_up_hit;
  logic              w_up_taken;
  logic              w_alloc;
  logic              w_train;
  logic              w_wr_entry;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_unused;

  // Byte offset within the instruction word never selects an entry.
  assign w_unused = ^{i_lk_pc[1:0], i_upd_pc[1:0]};

  assign w_lk_idx = i_lk_pc[IDX_W+1:2];
  assign w_lk_tag = i_lk_pc[AW-1:IDX_W+2];
  assign w_up_idx = i_upd_pc[IDX_W+1:2];
  assign w_up_tag = i_upd_pc[AW-1:IDX_W+2];

`ifdef BTP_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;
  // Counter table is hashed with global history; update uses pre-shift history.
  assign w_lk_cidx = w_lk_idx ^ r_ghr;
  assign w_up_cidx = w_up_idx ^ r_ghr;

  // Non-speculative history: conditional branches only, shifted in at resolve.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ghr <= '0;
    end else if (i_upd_valid && !i_upd_jump) begin
      r_ghr <= IDX_W'({r_ghr, i_upd_taken});
    end
  end
`else
  assign w_lk_cidx = w_lk_idx;
  assign w_up_cidx = w_up_idx;
`endif

  // Fetch-side lookup sees only committed state, so a same-cycle update is invisible.
  assign w_lk_cnt      = r_cnt[w_lk_cidx];
  assign w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken    = w_lk_hit && (r_jflag[w_lk_idx] || w_lk_cnt[CNT_W-1]);
  assign o_pred_hit    = w_lk_hit;
  assign o_pred_taken  = w_lk_taken;
  assign o_pred_target = w_lk_taken ? r_target[w_lk_idx] : '0;

  // Jumps are always treated as taken regardless of the reported direction.
  assign w_up_cnt   = r_cnt[w_up_cidx];
  assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_taken = i_upd_jump || i_upd_taken;
  assign w_alloc    = i_upd_valid && !w_up_hit && w_up_taken;
  assign w_train    = i_upd_valid && w_up_hit;
  assign w_wr_entry = w_alloc || (w_train && w_up_taken);

  // Next direction counter value: fresh entries start weakly taken, hits saturate.
  always_comb begin
    w_cnt_next = w_up_cnt;
    if (w_alloc) begin
      w_cnt_next = CNT_WT;
    end else if (w_train) begin
      if (w_up_taken && (w_up_cnt != CNT_MAX)) begin
        w_cnt_next = w_up_cnt + CNT_W'(1);
      end else if (!w_up_taken && (w_up_cnt != '0)) begin
        w_cnt_next = w_up_cnt - CNT_W'(1);
      end
    end
  end

  // Resettable state: valid bits, counters and statistics; reset drops any update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid   <= '0;
      r_stat_br <= '0;
      r_stat_mp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= CNT_WNT;
      end
    end else begin
      if (w_alloc) begin
        r_valid[w_up_idx] <= 1'b1;
      end
      if (w_alloc || w_train) begin
        r_cnt[w_up_cidx] <= w_cnt_next;
      end
      if (i_upd_valid && (r_stat_br != STAT_MAX)) begin
        r_stat_br <= r_stat_br + STAT_W'(1);
      end
      if (i_upd_valid && i_upd_mispred && (r_stat_mp != STAT_MAX)) begin
        r_stat_mp <= r_stat_mp + STAT_W'(1);
      end
    end
  end

  // Payload arrays carry no reset; valid gates their use.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_entry) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= i_upd_target;
    end
    if (!i_rst && (w_alloc || w_train)) begin
      r_jflag[w_up_idx] <= i_upd_jump;
    end
  end

  assign o_stat_branches = r_stat_br;
  assign o_stat_mispred  = r_stat_mp;

endmodule
